// File: rtl/id_issue.sv
// ID/EX issue stage: operand resolution (imm / zero / forward / regfile), hazard interlock,
// one-entry output register and stall counter. Define ID_ISSUE_FWD_EN to enable result forwarding.
module id_issue #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NUM_FWD = 3,
    parameter int unsigned CTRL_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_pc,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic [1:0]                in_re,
    input  logic [2*ADDR_W-1:0]       in_raddr,
    input  logic [DATA_W-1:0]         in_imm,
    input  logic                      in_wreg,
    input  logic [ADDR_W-1:0]         in_waddr,
    output logic [2*ADDR_W-1:0]       rf_raddr,
    input  logic [2*DATA_W-1:0]       rf_rdata,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_waddr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
    input  logic [NUM_FWD-1:0]        fwd_rdy,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_pc,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic                      out_wreg,
    output logic [ADDR_W-1:0]         out_waddr,
    output logic [2*DATA_W-1:0]       out_reg,
    output logic [31:0]               stall_cycles
);

    logic hazard;
    logic capture;

    assign rf_raddr = in_raddr;

`ifndef ID_ISSUE_FWD_EN
    logic unused_fwd;
    assign unused_fwd = ^{fwd_wdata, fwd_rdy};
`endif

    for (genvar n = 0; n < 2; n++) begin : g_op
        logic [ADDR_W-1:0] addr;
        logic              found;
        logic              haz;
        logic [DATA_W-1:0] val;
`ifdef ID_ISSUE_FWD_EN
        logic              win_rdy;
        logic [DATA_W-1:0] win_data;
`endif

        assign addr = in_raddr[n*ADDR_W +: ADDR_W];

        // The youngest matching source wins; older sources are never consulted.
        always_comb begin
            found = 1'b0;
`ifdef ID_ISSUE_FWD_EN
            win_rdy  = 1'b0;
            win_data = '0;
`endif
            for (int unsigned s = 0; s < NUM_FWD; s++) begin
                if (!found && fwd_we[s] && (fwd_waddr[s*ADDR_W +: ADDR_W] == addr)) begin
                    found = 1'b1;
`ifdef ID_ISSUE_FWD_EN
                    win_rdy  = fwd_rdy[s];
                    win_data = fwd_wdata[s*DATA_W +: DATA_W];
`endif
                end
            end
        end

        always_comb begin
            val = rf_rdata[n*DATA_W +: DATA_W];
            haz = 1'b0;
            if (!in_re[n]) begin
                val = in_imm;
            end else if (addr == '0) begin
                val = '0;
            end else if (found) begin
`ifdef ID_ISSUE_FWD_EN
                if (win_rdy) val = win_data;
                else         haz = 1'b1;
`else
                haz = 1'b1;
`endif
            end
        end
    end

    assign hazard   = in_valid && (g_op[0].haz || g_op[1].haz);
    assign in_ready = !rst && !hazard && !flush && (!out_valid || out_ready);
    assign capture  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_ctrl     <= '0;
            out_reg      <= '0;
            out_wreg     <= 1'b0;
            out_waddr    <= '0;
            stall_cycles <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (capture) begin
                out_valid <= 1'b1;
                out_pc    <= in_pc;
                out_ctrl  <= in_ctrl;
                out_reg   <= {g_op[1].val, g_op[0].val};
                out_wreg  <= in_wreg;
                out_waddr <= in_waddr;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (in_valid && hazard && !flush && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_id_issue.sv
// Scoreboard bench for id_issue: each cycle a reference model predicts in_ready/out_valid/stall
// count and pushes captured records, which are compared while held in the output register.
module tb_id_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [15:0] in_ctrl;
    logic [1:0]  in_re;
    logic [9:0]  in_raddr;
    logic [31:0] in_imm;
    logic        in_wreg;
    logic [4:0]  in_waddr;
    logic [9:0]  rf_raddr;
    logic [63:0] rf_rdata;
    logic [2:0]  fwd_we;
    logic [14:0] fwd_waddr;
    logic [95:0] fwd_wdata;
    logic [2:0]  fwd_rdy;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [15:0] out_ctrl;
    logic        out_wreg;
    logic [4:0]  out_waddr;
    logic [63:0] out_reg;
    logic [31:0] stall_cycles;

    typedef struct {
        logic [31:0] pc;
        logic [15:0] ctrl;
        logic [63:0] regs;
        logic        wreg;
        logic [4:0]  waddr;
    } exp_t;

    exp_t        sb[$];
    logic        m_valid = 1'b0;
    logic [31:0] m_stall = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    id_issue #(.DATA_W(32), .ADDR_W(5), .NUM_FWD(3), .CTRL_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_ctrl(in_ctrl), .in_re(in_re), .in_raddr(in_raddr), .in_imm(in_imm),
        .in_wreg(in_wreg), .in_waddr(in_waddr), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_rdy(fwd_rdy),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_ctrl(out_ctrl), .out_wreg(out_wreg), .out_waddr(out_waddr), .out_reg(out_reg),
        .stall_cycles(stall_cycles)
    );

    // Reference operand resolution from the bench-driven inputs.
    function automatic void model_op(input int n, output logic [31:0] val, output logic haz);
        logic [4:0] a;
        a   = in_raddr[n*5 +: 5];
        val = rf_rdata[n*32 +: 32];
        haz = 1'b0;
        if (!in_re[n]) val = in_imm;
        else if (a == 5'd0) val = 32'd0;
        else begin
            for (int s = 0; s < 3; s++) begin
                if (fwd_we[s] && fwd_waddr[s*5 +: 5] == a) begin
`ifdef ID_ISSUE_FWD_EN
                    if (fwd_rdy[s]) val = fwd_wdata[s*32 +: 32];
                    else haz = 1'b1;
`else
                    haz = 1'b1;
`endif
                    break;
                end
            end
        end
    endfunction

    task automatic set_idle();
        rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_ctrl = '0; in_re = 2'b11;
        in_raddr = '0; in_imm = '0; in_wreg = 1'b0; in_waddr = '0; rf_rdata = '0;
        fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0; fwd_rdy = '1; flush = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [1:0] re, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [31:0] imm);
        in_valid = 1'b1; in_pc = pc; in_ctrl = pc[15:0] ^ 16'hA5A5; in_re = re;
        in_raddr = {a2, a1}; in_imm = imm; in_wreg = pc[0]; in_waddr = pc[6:2];
        rf_rdata = {32'hB000_0000 | pc, 32'hA000_0000 | pc};
    endtask

    // One clock: inputs are already set; check just before the edge, advance the model, step.
    task automatic tick(input string tag);
        logic [31:0] v0, v1;
        logic        h0, h1, haz, rdy;
        exp_t        e;
        #7;
        model_op(0, v0, h0);
        model_op(1, v1, h1);
        haz = in_valid && (h0 || h1);
        rdy = !rst && !haz && !flush && (!m_valid || out_ready);
        n_checks++;
        if (in_ready !== rdy) begin
            n_fail++; $display("FAIL %s in_ready: got %b want %b", tag, in_ready, rdy);
        end
        n_checks++;
        if (out_valid !== m_valid) begin
            n_fail++; $display("FAIL %s out_valid: got %b want %b", tag, out_valid, m_valid);
        end
        n_checks++;
        if (stall_cycles !== m_stall) begin
            n_fail++; $display("FAIL %s stall_cycles: got %0d want %0d", tag, stall_cycles, m_stall);
        end
        n_checks++;
        if (rf_raddr !== in_raddr) begin
            n_fail++; $display("FAIL %s rf_raddr: got %h want %h", tag, rf_raddr, in_raddr);
        end
        if (m_valid && sb.size() > 0) begin
            e = sb[0];
            n_checks++;
            if (out_pc !== e.pc || out_ctrl !== e.ctrl || out_reg !== e.regs ||
                out_wreg !== e.wreg || out_waddr !== e.waddr) begin
                n_fail++;
                $display("FAIL %s out_fields: got pc=%h ctrl=%h reg=%h w=%b wa=%0d want pc=%h ctrl=%h reg=%h w=%b wa=%0d",
                         tag, out_pc, out_ctrl, out_reg, out_wreg, out_waddr,
                         e.pc, e.ctrl, e.regs, e.wreg, e.waddr);
            end
        end
        if (rst) begin
            m_valid = 1'b0; m_stall = '0; sb.delete();
        end else begin
            if (m_valid && (out_ready || flush) && sb.size() > 0) void'(sb.pop_front());
            if (flush) m_valid = 1'b0;
            else if (in_valid && rdy) begin
                e.pc = in_pc; e.ctrl = in_ctrl; e.regs = {v1, v0};
                e.wreg = in_wreg; e.waddr = in_waddr;
                sb.push_back(e);
                m_valid = 1'b1;
            end else if (out_ready) m_valid = 1'b0;
            if (in_valid && haz && !flush && m_stall != 32'hFFFF_FFFF) m_stall++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        offer(32'h100, 2'b11, 5'd1, 5'd2, 32'h0);
        tick("reset0");
        tick("reset1");
        n_checks++;
        if ({out_valid, out_pc, out_ctrl, out_reg, out_wreg, out_waddr, stall_cycles} !== '0) begin
            n_fail++; $display("FAIL reset_state: got v=%b pc=%h reg=%h stall=%0d want all zero",
                               out_valid, out_pc, out_reg, stall_cycles);
        end
        set_idle();
        tick("reset_idle");
    endtask

    task automatic test_imm_zero();
        offer(32'h200, 2'b00, 5'd7, 5'd9, 32'h1234);
        tick("imm");
        n_checks++;
        if (out_reg !== {32'h1234, 32'h1234}) begin
            n_fail++; $display("FAIL imm_operands: got %h want %h", out_reg, {32'h1234, 32'h1234});
        end
        offer(32'h204, 2'b01, 5'd0, 5'd4, 32'h0);
        fwd_we = 3'b001; fwd_waddr = {10'd0, 5'd0}; fwd_wdata = {64'd0, 32'hFF};
        tick("zero_reg");
        n_checks++;
        if (out_reg[31:0] !== 32'd0) begin
            n_fail++; $display("FAIL zero_reg_op1: got %h want 0", out_reg[31:0]);
        end
        set_idle();
        tick("imm_drain");
    endtask

    task automatic test_fwd_priority();
        offer(32'h300, 2'b01, 5'd3, 5'd0, 32'h0);
        fwd_we = 3'b101; fwd_waddr = {5'd3, 5'd0, 5'd3};
        fwd_wdata = {32'h22, 32'h0, 32'h11}; fwd_rdy = 3'b111;
`ifdef ID_ISSUE_FWD_EN
        tick("fwd_prio");
        n_checks++;
        if (out_reg[31:0] !== 32'h11) begin
            n_fail++; $display("FAIL fwd_priority: got %h want 00000011", out_reg[31:0]);
        end
`else
        tick("fwd_prio_interlock0");
        tick("fwd_prio_interlock1");
        fwd_we = 3'b000;
        tick("fwd_prio_release");
`endif
        set_idle();
        tick("fwd_drain");
    endtask

    task automatic test_load_stall();
        logic [31:0] s0;
        s0 = m_stall;
        offer(32'h400, 2'b11, 5'd5, 5'd6, 32'h0);
        fwd_we = 3'b001; fwd_waddr = {10'd0, 5'd5}; fwd_wdata = {64'd0, 32'hCAFE}; fwd_rdy = 3'b110;
        tick("load_stall0");
        tick("load_stall1");
        n_checks++;
        if (stall_cycles - s0 !== 32'd2) begin
            n_fail++; $display("FAIL load_stall_count: got %0d want 2", stall_cycles - s0);
        end
`ifdef ID_ISSUE_FWD_EN
        fwd_rdy = 3'b111;
        tick("load_capture");
        n_checks++;
        if (out_reg[31:0] !== 32'hCAFE) begin
            n_fail++; $display("FAIL load_fwd_data: got %h want 0000cafe", out_reg[31:0]);
        end
`else
        fwd_we = 3'b000;
        tick("load_capture");
`endif
        set_idle();
        tick("load_drain");
    endtask

    task automatic test_back_to_back();
        logic [31:0] held;
        offer(32'h500, 2'b11, 5'd1, 5'd2, 32'h0);
        tick("bp_first");
        held = out_pc;
        out_ready = 1'b0;
        offer(32'h504, 2'b11, 5'd3, 5'd4, 32'h0);
        for (int i = 0; i < 3; i++) tick("bp_hold");
        n_checks++;
        if (out_pc !== 32'h500 || held !== 32'h500) begin
            n_fail++; $display("FAIL bp_hold_pc: got %h want 00000500", out_pc);
        end
        out_ready = 1'b1;
        tick("bp_release");
        offer(32'h508, 2'b11, 5'd5, 5'd6, 32'h0);
        tick("bp_next");
        n_checks++;
        if (out_pc !== 32'h508 || !out_valid) begin
            n_fail++; $display("FAIL back_to_back: got pc=%h v=%b want pc=00000508 v=1", out_pc, out_valid);
        end
        set_idle();
        tick("bp_drain");
    endtask

    task automatic test_flush();
        offer(32'h600, 2'b11, 5'd1, 5'd2, 32'h0);
        out_ready = 1'b0;
        tick("flush_load");
        offer(32'h604, 2'b11, 5'd3, 5'd4, 32'h0);
        flush = 1'b1;
        tick("flush");
        set_idle();
        tick("flush_after");
        n_checks++;
        if (out_valid !== 1'b0 || out_pc === 32'h604) begin
            n_fail++; $display("FAIL flush_drop: got v=%b pc=%h want v=0 pc!=00000604", out_valid, out_pc);
        end
    endtask

    task automatic test_interlock();
`ifndef ID_ISSUE_FWD_EN
        offer(32'h700, 2'b10, 5'd0, 5'd8, 32'h0);
        fwd_we = 3'b010; fwd_waddr = {5'd0, 5'd8, 5'd0}; fwd_wdata = {32'h0, 32'hDEAD, 32'h0};
        fwd_rdy = 3'b111;
        tick("interlock_haz");
        fwd_we = 3'b000;
        tick("interlock_rf");
        n_checks++;
        if (out_reg[63:32] !== 32'hB000_0700) begin
            n_fail++; $display("FAIL interlock_rfdata: got %h want b0000700", out_reg[63:32]);
        end
        set_idle();
        tick("interlock_drain");
`endif
    endtask

    task automatic test_reset_mid_stall();
        offer(32'h800, 2'b11, 5'd1, 5'd2, 32'h0);
        tick("rms_load");
        out_ready = 1'b0;
        offer(32'h804, 2'b11, 5'd9, 5'd2, 32'h0);
        fwd_we = 3'b001; fwd_waddr = {10'd0, 5'd9}; fwd_rdy = 3'b110;
        tick("rms_stall");
        rst = 1'b1;
        tick("rms_reset");
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'd0) begin
            n_fail++; $display("FAIL reset_mid_stall: got v=%b pc=%h want v=0 pc=0", out_valid, out_pc);
        end
        set_idle();
        tick("rms_drain");
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            offer(32'h1000 + 32'(i) * 4, 2'($urandom), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), $urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            rf_rdata  = {$urandom, $urandom};
            fwd_we    = 3'($urandom);
            fwd_waddr = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            fwd_wdata = {$urandom, $urandom, $urandom};
            fwd_rdy   = 3'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            tick("random");
        end
        set_idle();
        tick("random_drain");
    endtask

    initial begin
        set_idle();
        test_reset();
        test_imm_zero();
        test_fwd_priority();
        test_load_stall();
        test_back_to_back();
        test_flush();
        test_interlock();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_issue.md
ID_ISSUE -- requirements
Module: id_issue

Interface
REQ-001 Parameter DATA_W, default 32, operand/data width.
REQ-002 Parameter ADDR_W, default 5, register address width.
REQ-003 Parameter NUM_FWD, default 3, forwarding source count; index 0 = youngest (EX), rising index = older (MEM, WB).
REQ-004 Parameter CTRL_W, default 16, opaque decoded control word width (aluop/alusel/hilo flags).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  decoded instruction offered.
REQ-008 in_ready  output  1  stage accepts offered instruction this cycle.
REQ-009 in_pc  input  DATA_W  instruction PC.
REQ-010 in_ctrl  input  CTRL_W  decoded control word.
REQ-011 in_re  input  2  read enable per operand; bit0 = operand 1, bit1 = operand 2.
REQ-012 in_raddr  input  2*ADDR_W  source addresses, [ADDR_W-1:0] = operand 1.
REQ-013 in_imm  input  DATA_W  immediate, used when an operand's read enable is 0.
REQ-014 in_wreg  input  1  instruction writes a register.
REQ-015 in_waddr  input  ADDR_W  destination register.
REQ-016 rf_raddr  output  2*ADDR_W  register file read addresses, equal to in_raddr combinationally.
REQ-017 rf_rdata  input  2*DATA_W  register file read data, same cycle.
REQ-018 fwd_we  input  NUM_FWD  per-source write enable.
REQ-019 fwd_waddr  input  NUM_FWD*ADDR_W  per-source destination.
REQ-020 fwd_wdata  input  NUM_FWD*DATA_W  per-source result.
REQ-021 fwd_rdy  input  NUM_FWD  per-source result valid now; 0 = not yet produced (load in flight).
REQ-022 flush  input  1  discard held and offered instructions.
REQ-023 out_valid  output  1  ID/EX register holds a valid instruction.
REQ-024 out_ready  input  1  EX accepts out_* this cycle.
REQ-025 out_pc, out_ctrl, out_wreg, out_waddr  output  DATA_W, CTRL_W, 1, ADDR_W  registered copies of the in_* fields.
REQ-026 out_reg  output  2*DATA_W  registered resolved operands, [DATA_W-1:0] = operand 1.
REQ-027 stall_cycles  output  32  saturating hazard-stall counter.

Function
REQ-028 Operand n SHALL resolve as: in_re[n]=0 -> in_imm; address 0 -> 0; else lowest-index source with fwd_we=1 and matching fwd_waddr -> fwd_wdata; no match -> rf_rdata[n].
REQ-029 Hazard SHALL assert when in_valid and an enabled nonzero operand's winning source has fwd_rdy=0; older matching sources SHALL NOT be consulted.
REQ-030 in_ready SHALL equal !hazard && !flush && (!out_valid || out_ready).
REQ-031 Capture (in_valid && in_ready) SHALL load all out_* fields and set out_valid=1 on the next edge; latency 1 cycle.
REQ-032 Without capture, out_valid SHALL clear when out_ready=1 and hold otherwise; out_* fields SHALL hold while out_valid=1 and out_ready=0.
REQ-033 flush SHALL clear out_valid on the next edge and drop the offered instruction; flush wins over simultaneous capture and hazard.
REQ-034 stall_cycles SHALL increment each cycle with in_valid && hazard && !flush, saturating at 0xFFFFFFFF.
REQ-035 in_ready and operand resolution SHALL be purely combinational; no state besides the output register and counter.

Reset
REQ-036 rst SHALL clear out_valid, out_pc, out_ctrl, out_reg, out_wreg, out_waddr and stall_cycles to 0 on the next edge; in_ready SHALL be 0 while rst=1.
REQ-037 rst asserted mid-stall SHALL discard the held instruction; no capture occurs in the reset cycle.

Configuration
REQ-038 With ID_ISSUE_FWD_EN defined, operands SHALL resolve per REQ-028/029.
REQ-039 Without ID_ISSUE_FWD_EN, any matching fwd_we source SHALL raise hazard regardless of fwd_rdy and fwd_wdata SHALL never be selected (interlock-only).

Verification
REQ-040 in_raddr op1=3, fwd0 we=1 addr=3 data=0x11, fwd2 we=1 addr=3 data=0x22 -> out_reg op1=0x11 next cycle.
REQ-041 op1 addr=0, fwd0 we=1 addr=0 data=0xFF -> out_reg op1=0; in_re=2'b00, in_imm=0x1234 -> both operands 0x1234.
REQ-042 fwd0 match with fwd_rdy=0 for 2 cycles -> in_ready=0 two cycles, stall_cycles=2, capture on cycle 3 with forwarded data.
REQ-043 out_valid=1, out_ready=0 for 3 cycles, new in_valid -> in_ready=0, out_* unchanged; out_ready=1 -> back-to-back capture, no bubble.
REQ-044 flush with in_valid=1, out_valid=1 -> out_valid=0 next cycle, offered instruction never appears.
REQ-045 Without ID_ISSUE_FWD_EN, fwd1 match with fwd_rdy=1 -> hazard; clearing fwd1 we -> capture with rf_rdata.
